lsu_access_ctrl: RTL
====================

Name: lsu_access_ctrl

Overview:
- Sequences every load/store from the MEM stage onto the single-ported, variable-latency data memory.
- Generates byte enables and lane-replicated write data, and detects misaligned accesses.
- Stalls the pipeline until memory acknowledges, then presents the raw read word, latched op and address low bits to the downstream load-extension stage.
- Honours an interrupt flush from the exception unit.

Parameters:
- MAX_WAIT, 16, cycles in ACCESS without mem_ack before a bus error is raised; range 1..255.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- valid  in  1  MEM stage holds a load/store this cycle
- op  in  6  opcode [31:26]: lb 20, lh 21, lw 23, lbu 24, lhu 25, sb 28, sh 29, sw 2b (hex); any other value is ignored
- addr  in  32  effective byte address
- wdata  in  32  store data, unaligned, in low bits
- flush  in  1  interrupt/exception flush of the MEM stage
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  32  read word
- stall  out  1  freeze IF..MEM
- done  out  1  one-cycle pulse: access completed and its result is valid
- rdata_raw  out  32  latched read word for the extension stage
- op_q  out  6  latched opcode
- addr_lo  out  2  latched addr[1:0]
- adel  out  1  one-cycle pulse: misaligned load
- ades  out  1  one-cycle pulse: misaligned store
- bus_err  out  1  one-cycle pulse: timeout
- badvaddr  out  32  faulting address, held until the next fault

Behaviour:
- Reset: state=IDLE, and every output is 0. This covers mem_* signals, done, stall, rdata_raw, op_q, addr_lo, adel, ades, bus_err and badvaddr. The wait counter is also 0. A reset in any state aborts the access with no done.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Start condition is valid & recognised op & !flush.
  - Aligned start: latch op, addr, byte enables and replicated data; go to ACCESS. stall=1 combinationally in this same cycle.
  - Misaligned start: no transition and no memory access. Pulse adel (loads) or ades (stores) next cycle and load badvaddr=addr. stall=0.
  - Misalignment rules: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0. Bytes are never misaligned.
  - flush=1 in IDLE suppresses start, faults and all pulses.
- ACCESS:
  - mem_req=1; mem_we=1 for stores only; mem_addr, mem_be and mem_wdata held stable from the latched values. stall=1.
  - The counter increments each cycle without ack.
  - mem_ack=1: capture mem_rdata into rdata_raw (loads only), clear the counter, go to DONE.
  - Counter reaches MAX_WAIT without ack: pulse bus_err, load badvaddr, return to IDLE, no done.
  - flush while in ACCESS: set a sticky kill bit. The transaction still completes on ack because stores are not retracted. On completion: done suppressed, rdata_raw not updated, return directly to IDLE.
- DONE:
  - done=1 for exactly one cycle; stall=0 so the pipeline advances this cycle; go to IDLE.
  - Back-to-back accesses therefore need at least 1 idle cycle between them.
- Latency: an ack on the first ACCESS cycle gives a fixed 3 cycles from valid to done (IDLE accept, ACCESS, DONE).
- Byte enables:
  - sb: 4'b0001<<addr[1:0]
  - sh: addr[1] ? 4'b1100 : 4'b0011
  - sw: 4'b1111
  - loads: 4'b1111
- Write data:
  - sb: {4{wdata[7:0]}}
  - sh: {2{wdata[15:0]}}
  - sw: wdata
- mem_ack outside ACCESS is ignored.
- op_q and addr_lo update only on accepted starts and persist after done.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW);
  - the lsu_state_t enum;
  - is_load/is_store/misaligned helper functions, reused by the decoder.
- One natural combinational sub-module, lsu_store_align: op + addr[1:0] + wdata -> mem_be + mem_wdata.

Test Plan:
- lw addr=0x100, ack on first ACCESS cycle, rdata=0xDEADBEEF -> mem_be=4'b1111, mem_addr=0x100; done pulses 3rd cycle with rdata_raw=0xDEADBEEF, op_q=6'h23; stall high 2 cycles.
- sb addr=0x203, wdata=0x000000A5, ack after 4 wait cycles -> mem_we=1, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200; stall high 6 cycles; done 1 cycle.
- lh addr=0x101 -> adel pulse, badvaddr=0x101, mem_req never asserted, stall=0. Repeat with sw addr=0x102 -> ades pulse, badvaddr=0x102.
- lw with mem_ack never asserted, MAX_WAIT=16 -> bus_err pulses after 16 ACCESS cycles, badvaddr=addr, state IDLE, no done.
- sh addr=0x300, wdata=0x1234, flush in 2nd ACCESS cycle, ack on 3rd -> mem_be=4'b0011, mem_wdata=0x12341234, write completes, done never pulses, stall drops the cycle after ack.
- rst asserted mid-ACCESS -> next cycle all outputs 0 and state IDLE; a later ack is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store opcodes, LSU state encoding and
// opcode classification helpers used by the LSU and the decoder.
package cpu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
        logic half;
        logic word;
        half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word = (op == OP_LW) || (op == OP_SW);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane steering: byte enables and lane-replicated
// write data from opcode, address low bits and unaligned store data.
module lsu_store_align
    import cpu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Each lane takes the store byte that would land on it after replication.
            assign mem_be[gi] = (op == OP_SB) ? (addr_lo == 2'(gi)) :
                                (op == OP_SH) ? (addr_lo[1] == 1'(gi / 2)) :
                                ((op == OP_SW) || is_load(op));
            assign mem_wdata[8*gi +: 8] = (op == OP_SB) ? wdata[7:0] :
                                          (op == OP_SH) ? wdata[8*(gi % 2) +: 8] :
                                          wdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer for the single-ported data memory: alignment faults,
// pipeline stall until ack, timeout bus error and flush-kill of in-flight accesses.
module lsu_access_ctrl
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_raw,
    output logic [5:0]  op_q,
    output logic [1:0]  addr_lo,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic [31:0] badvaddr
);

    lsu_state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic             kill_reg;
    logic [5:0]       op_reg;
    logic [31:0]      addr_reg;
    logic [3:0]       be_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic             adel_reg, ades_reg, bus_err_reg;
    logic [31:0]      badvaddr_reg;

    logic [3:0]       be_new;
    logic [31:0]      wdata_new;
    logic             start, accept, fault, timeout, in_access;

    lsu_store_align u_align (
        .op        (op),
        .addr_lo   (addr[1:0]),
        .wdata     (wdata),
        .mem_be    (be_new),
        .mem_wdata (wdata_new)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        in_access  = (state_reg == ST_ACCESS);
        start      = valid && (is_load(op) || is_store(op)) && !flush;
        accept     = (state_reg == ST_IDLE) && start && !misaligned(op, addr[1:0]);
        fault      = (state_reg == ST_IDLE) && start && misaligned(op, addr[1:0]);
        timeout    = in_access && !mem_ack && (cnt_reg == CNT_W'(MAX_WAIT - 1));
        case (state_reg)
            ST_IDLE: begin
                stall = accept;
                if (accept) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_req = 1'b1;
                mem_we  = is_store(op_reg);
                stall   = 1'b1;
                // A flushed access still completes on the bus but reports nothing.
                if (mem_ack)      state_next = (kill_reg || flush) ? ST_IDLE : ST_DONE;
                else if (timeout) state_next = ST_IDLE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            kill_reg     <= 1'b0;
            op_reg       <= '0;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            adel_reg     <= 1'b0;
            ades_reg     <= 1'b0;
            bus_err_reg  <= 1'b0;
            badvaddr_reg <= '0;
        end else begin
            if (accept) begin
                op_reg    <= op;
                addr_reg  <= addr;
                be_reg    <= be_new;
                wdata_reg <= wdata_new;
            end
            adel_reg    <= fault && is_load(op);
            ades_reg    <= fault && is_store(op);
            bus_err_reg <= timeout;
            if (fault)        badvaddr_reg <= addr;
            else if (timeout) badvaddr_reg <= addr_reg;
            if (in_access && !mem_ack && !timeout) begin
                cnt_reg  <= cnt_reg + 1'b1;
                kill_reg <= kill_reg || flush;
            end else begin
                cnt_reg  <= '0;
                kill_reg <= 1'b0;
            end
            if (in_access && mem_ack && !(kill_reg || flush) && is_load(op_reg))
                rdata_reg <= mem_rdata;
        end
    end

    assign mem_be    = be_reg;
    assign mem_addr  = {addr_reg[31:2], 2'b00};
    assign mem_wdata = wdata_reg;
    assign rdata_raw = rdata_reg;
    assign op_q      = op_reg;
    assign addr_lo   = addr_reg[1:0];
    assign adel      = adel_reg;
    assign ades      = ades_reg;
    assign bus_err   = bus_err_reg;
    assign badvaddr  = badvaddr_reg;

endmodule
